// File: rtl/execute_cycle_if.sv
// ID/EX inputs, writeback bypass and EX/MEM outputs of the execute stage.
// The bench/decode side uses master, the execute stage uses slave.
interface execute_cycle_if #(
    parameter int XLEN = 32
);
    logic            StallE;
    logic            RegWriteE;
    logic            MemWriteE;
    logic            ResultSrcE;
    logic            BranchE;
    logic            JumpE;
    logic            ALUSrcE;
    logic [3:0]      ALUControlE;
    logic [XLEN-1:0] RD1_E;
    logic [XLEN-1:0] RD2_E;
    logic [XLEN-1:0] Imm_Ext_E;
    logic [XLEN-1:0] PCE;
    logic [XLEN-1:0] PCPlus4E;
    logic [4:0]      RS1_E;
    logic [4:0]      RS2_E;
    logic [4:0]      RD_E;
    logic [XLEN-1:0] ResultW;
    logic            RegWriteW;
    logic [4:0]      RDW;
    logic            PCSrcE;
    logic [XLEN-1:0] PCTargetE;
    logic            RegWriteM;
    logic            MemWriteM;
    logic            ResultSrcM;
    logic [4:0]      RD_M;
    logic [XLEN-1:0] ALUResultM;
    logic [XLEN-1:0] WriteDataM;
    logic [XLEN-1:0] PCPlus4M;

    modport master (
        output StallE, RegWriteE, MemWriteE, ResultSrcE,
        output BranchE, JumpE, ALUSrcE, ALUControlE,
        output RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E,
        output RS1_E, RS2_E, RD_E,
        output ResultW, RegWriteW, RDW,
        input  PCSrcE, PCTargetE,
        input  RegWriteM, MemWriteM, ResultSrcM, RD_M,
        input  ALUResultM, WriteDataM, PCPlus4M
    );

    modport slave (
        input  StallE, RegWriteE, MemWriteE, ResultSrcE,
        input  BranchE, JumpE, ALUSrcE, ALUControlE,
        input  RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E,
        input  RS1_E, RS2_E, RD_E,
        input  ResultW, RegWriteW, RDW,
        output PCSrcE, PCTargetE,
        output RegWriteM, MemWriteM, ResultSrcM, RD_M,
        output ALUResultM, WriteDataM, PCPlus4M
    );
endinterface

// File: rtl/execute_cycle.sv
// RV32I execute stage: forwarding, ALU, branch resolve, EX/MEM register.
// Define EXEC_MUL_EN to add a single-cycle MUL on ALU code 1010.
module execute_cycle #(
    parameter int XLEN = 32
) (
    input  logic                clk,
    input  logic                rst,
    execute_cycle_if.slave      bus
);
    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] fwd_b;
    logic [XLEN-1:0] src_b;
    logic [XLEN-1:0] alu_res;
    logic [XLEN-1:0] ex_res;
    logic            zero;
    logic            m_hit_a;
    logic            w_hit_a;
    logic            m_hit_b;
    logic            w_hit_b;

    // x0 is hardwired, so a write to it must never be bypassed
    assign m_hit_a = bus.RegWriteM && (bus.RD_M != 5'd0)
                  && (bus.RD_M == bus.RS1_E);
    assign w_hit_a = bus.RegWriteW && (bus.RDW != 5'd0)
                  && (bus.RDW == bus.RS1_E);
    assign m_hit_b = bus.RegWriteM && (bus.RD_M != 5'd0)
                  && (bus.RD_M == bus.RS2_E);
    assign w_hit_b = bus.RegWriteW && (bus.RDW != 5'd0)
                  && (bus.RDW == bus.RS2_E);

    always_comb begin
        src_a = bus.RD1_E;
        if (m_hit_a)
            src_a = bus.ALUResultM;
        else if (w_hit_a)
            src_a = bus.ResultW;
    end

    always_comb begin
        fwd_b = bus.RD2_E;
        if (m_hit_b)
            fwd_b = bus.ALUResultM;
        else if (w_hit_b)
            fwd_b = bus.ResultW;
    end

    assign src_b = bus.ALUSrcE ? bus.Imm_Ext_E : fwd_b;

    always_comb begin
        alu_res = '0;
        unique case (bus.ALUControlE)
            4'b0000: alu_res = src_a & src_b;
            4'b0001: alu_res = src_a | src_b;
            4'b0010: alu_res = src_a + src_b;
            4'b0011: alu_res = src_a ^ src_b;
            4'b0100: alu_res = src_a << src_b[4:0];
            4'b0101: alu_res = src_a >> src_b[4:0];
            4'b1000: alu_res = $signed(src_a) >>> src_b[4:0];
            4'b0110: alu_res = src_a - src_b;
            4'b0111: alu_res = {{(XLEN-1){1'b0}},
                                ($signed(src_a) < $signed(src_b))};
            4'b1001: alu_res = {{(XLEN-1){1'b0}}, (src_a < src_b)};
`ifdef EXEC_MUL_EN
            4'b1010: alu_res = src_a * src_b;
`endif
            default: alu_res = '0;
        endcase
    end

    // BEQ relies on decode issuing SUB, so equality shows up as zero
    assign zero          = (alu_res == '0);
    assign bus.PCTargetE = bus.PCE + bus.Imm_Ext_E;
    assign bus.PCSrcE    = (bus.BranchE & zero) | bus.JumpE;
    assign ex_res        = bus.JumpE ? bus.PCPlus4E : alu_res;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.RegWriteM  <= 1'b0;
            bus.MemWriteM  <= 1'b0;
            bus.ResultSrcM <= 1'b0;
            bus.RD_M       <= '0;
            bus.ALUResultM <= '0;
            bus.WriteDataM <= '0;
            bus.PCPlus4M   <= '0;
        end else if (!bus.StallE) begin
            bus.RegWriteM  <= bus.RegWriteE;
            bus.MemWriteM  <= bus.MemWriteE;
            bus.ResultSrcM <= bus.ResultSrcE;
            bus.RD_M       <= bus.RD_E;
            bus.ALUResultM <= ex_res;
            bus.WriteDataM <= fwd_b;
            bus.PCPlus4M   <= bus.PCPlus4E;
        end
    end
endmodule
